// File: rtl/multi_issue_instruction_queue.sv
// Multi-lane in-order instruction queue between decode and issue/rename.
// Optional same-cycle enqueue->dequeue bypass when empty: define IQ_BYPASS_EN.
module multi_issue_instruction_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ENQ_W  = 2,
  parameter int unsigned DEQ_W  = 2,
  parameter int unsigned DATA_W = 64
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       flush_i,
  input  logic [ENQ_W-1:0]           enq_valid_i,
  input  logic [ENQ_W*DATA_W-1:0]    enq_data_i,
  output logic [ENQ_W-1:0]           enq_ready_o,
  output logic [DEQ_W-1:0]           deq_valid_o,
  output logic [DEQ_W*DATA_W-1:0]    deq_data_o,
  input  logic [DEQ_W-1:0]           deq_ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [$clog2(DEPTH):0]     free_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  free_c, n_vld, n_enq, n_deq;
  logic [CNT_W-1:0]  rank [ENQ_W];
  logic [ENQ_W-1:0]  acc, wr_en;
  logic [PTR_W-1:0]  wr_addr [ENQ_W];
  logic              take;

  // Lane ranking, handshakes, read mux and pointer arithmetic
  always_comb begin
    free_c      = CNT_W'(DEPTH) - count_q;
    n_vld       = '0;
    n_enq       = '0;
    acc         = '0;
    enq_ready_o = '0;
    for (int i = 0; i < ENQ_W; i++) begin
      rank[i]        = n_vld;
      enq_ready_o[i] = rstn_i & ~flush_i & (n_vld < free_c);
      acc[i]         = enq_valid_i[i] & enq_ready_o[i];
      if (enq_valid_i[i]) n_vld = n_vld + CNT_W'(1);
      if (acc[i])         n_enq = n_enq + CNT_W'(1);
    end

    deq_valid_o = '0;
    deq_data_o  = '0;
    for (int j = 0; j < DEQ_W; j++) begin
      deq_valid_o[j] = (count_q > CNT_W'(j));
      if (deq_valid_o[j])
        deq_data_o[j*DATA_W +: DATA_W] = mem_q[head_q + PTR_W'(j)];
    end
`ifdef IQ_BYPASS_EN
    // Empty queue: accepted lanes appear on the output in packed order
    if (count_q == '0 && !flush_i) begin
      for (int j = 0; j < DEQ_W; j++) begin
        for (int i = 0; i < ENQ_W; i++) begin
          if (acc[i] && rank[i] == CNT_W'(j)) begin
            deq_valid_o[j]                 = 1'b1;
            deq_data_o[j*DATA_W +: DATA_W] = enq_data_i[i*DATA_W +: DATA_W];
          end
        end
      end
    end
`endif

    n_deq = '0;
    take  = 1'b1;
    for (int j = 0; j < DEQ_W; j++) begin
      if (take && deq_valid_o[j] && deq_ready_i[j]) n_deq = n_deq + CNT_W'(1);
      else                                          take  = 1'b0;
    end

    for (int i = 0; i < ENQ_W; i++) begin
      wr_addr[i] = tail_q + PTR_W'(rank[i]);
      wr_en[i]   = acc[i];
`ifdef IQ_BYPASS_EN
      // Bypassed-and-consumed lanes never land in storage
      if (count_q == '0 && rank[i] < n_deq) wr_en[i] = 1'b0;
`endif
    end

    head_d  = head_q + PTR_W'(n_deq);
    tail_d  = tail_q + PTR_W'(n_enq);
    count_d = count_q + n_enq - n_deq;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < ENQ_W; i++) begin
      if (wr_en[i]) mem_q[wr_addr[i]] <= enq_data_i[i*DATA_W +: DATA_W];
    end
  end

  assign count_o = count_q;
  assign free_o  = free_c;
  assign full_o  = ~rstn_i | (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule
